// File: rtl/fpu_out_sched_pkg.sv
// fpu_out_sched_pkg: shared constants for the FPU result-return scheduler.
// Requester indices, result-ID field positions and the starvation counter type
// live here so the other FPU arbiters can decode the same fields.
package fpu_out_sched_pkg;

    localparam int REQ_ADD = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_DIV = 2;
    localparam int NUM_REQ = 3;

    localparam int ID_CORE_HI = 9;
    localparam int ID_CORE_LO = 7;
    localparam int ID_THR_HI  = 6;
    localparam int ID_THR_LO  = 5;

    localparam int STARVE_W = 4;
    typedef logic [STARVE_W-1:0] starve_cnt_t;

    // Round-robin start index for the cycle after the given one-hot winner.
    function automatic logic [1:0] rr_next_ptr(input logic [NUM_REQ-1:0] winner);
        logic [1:0] ptr;
        ptr = 2'(REQ_ADD);
        case (winner)
            3'b001:  ptr = 2'(REQ_MUL);
            3'b010:  ptr = 2'(REQ_DIV);
            default: ptr = 2'(REQ_ADD);
        endcase
        return ptr;
    endfunction

endpackage

// File: rtl/fpu_out_rr_pick.sv
// fpu_out_rr_pick: combinational rotating-priority picker for three requesters.
// ptr names the requester with highest priority; priority then falls through
// the following indices modulo three. Output is one-hot or zero.
module fpu_out_rr_pick (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    // Walk the requesters in rotated order starting at ptr; first hit wins.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/fpu_out_sched.sv
// fpu_out_sched: returns add/mul/div pipe results to the CPX request port.
// One registered grant per cycle, round-robin with a starvation override,
// gated by a CPX queue credit count.
// Optional macro FPU_OUT_SCHED_PERF_EN adds grant/stall performance counters
// and their synchronous clear input.
module fpu_out_sched
    import fpu_out_sched_pkg::*;
#(
    parameter int ID_W       = 10,
    parameter int CREDITS    = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic                    rclk,
    input  logic                    arst_l,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    input  logic                    cpx_credit_ret,
    output logic [NUM_REQ-1:0]      dest_rdy,
    output logic [7:0]              fp_cpx_req_cq,
    output logic [1:0]              req_thread,
    output logic [2:0]              credit_cnt,
    output logic                    credit_ovf
`ifdef FPU_OUT_SCHED_PERF_EN
    ,
    input  logic                    perf_clr,
    output logic [NUM_REQ-1:0][15:0] perf_cnt,
    output logic [15:0]             stall_cnt
`endif
);

    localparam logic [2:0]  CREDIT_MAX = 3'(CREDITS);
    localparam starve_cnt_t STARVE_LIM = starve_cnt_t'(STARVE_MAX);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] starved;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               grant_any;
    logic [1:0]         rr_ptr;
    logic [ID_W-1:0]    win_id;
    logic [2:0]         win_core;
    logic [1:0]         win_thr;
    logic               id_opaque_unused;
    starve_cnt_t        starve_cnt [NUM_REQ];

    // A requester that was granted last cycle is still showing its old result.
    assign eligible = req_vld & ~dest_rdy;

    // Flag eligible requesters whose wait has reached the starvation limit.
    always_comb begin
        starved = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            starved[k] = eligible[k] && (starve_cnt[k] == STARVE_LIM);
        end
    end

    fpu_out_rr_pick u_rr_pick (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    // Pick this cycle's winner: nothing without credit, starved lowest-index first, else round-robin.
    always_comb begin
        gnt = '0;
        if (credit_cnt != 3'd0) begin
            if      (starved[REQ_ADD]) gnt[REQ_ADD] = 1'b1;
            else if (starved[REQ_MUL]) gnt[REQ_MUL] = 1'b1;
            else if (starved[REQ_DIV]) gnt[REQ_DIV] = 1'b1;
            else                       gnt = rr_gnt;
        end
    end

    assign grant_any = |gnt;

    // Mux the winner's ID out of the packed request bus.
    always_comb begin
        win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) win_id = win_id | req_id[k*ID_W +: ID_W];
        end
    end

    assign win_core = win_id[ID_CORE_HI:ID_CORE_LO];
    assign win_thr  = win_id[ID_THR_HI:ID_THR_LO];
    // The low ID bits are opaque to the scheduler and travel with the result elsewhere.
    assign id_opaque_unused = ^win_id[ID_THR_LO-1:0];

    // Register the grant, its decoded CPX destination and thread, and advance the rr pointer.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            dest_rdy      <= '0;
            fp_cpx_req_cq <= 8'h00;
            req_thread    <= 2'b00;
            rr_ptr        <= 2'(REQ_ADD);
        end else begin
            dest_rdy      <= gnt;
            fp_cpx_req_cq <= grant_any ? (8'h01 << win_core) : 8'h00;
            if (grant_any) begin
                req_thread <= win_thr;
                rr_ptr     <= rr_next_ptr(gnt);
            end
        end
    end

    // Credit accounting: grants consume, returns refill, an excess return is flagged sticky.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            credit_cnt <= CREDIT_MAX;
            credit_ovf <= 1'b0;
        end else begin
            if (grant_any && !cpx_credit_ret) begin
                credit_cnt <= credit_cnt - 3'd1;
            end else if (!grant_any && cpx_credit_ret) begin
                if (credit_cnt == CREDIT_MAX) credit_ovf <= 1'b1;
                else                          credit_cnt <= credit_cnt + 3'd1;
            end
        end
    end

    // Per-requester wait counters, saturating; cleared by a grant or an idle request line.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int k = 0; k < NUM_REQ; k++) starve_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_vld[k] || gnt[k])        starve_cnt[k] <= '0;
                else if (starve_cnt[k] != STARVE_LIM) starve_cnt[k] <= starve_cnt[k] + starve_cnt_t'(1);
            end
        end
    end

`ifdef FPU_OUT_SCHED_PERF_EN
    // Saturating grant and zero-credit stall counters with a synchronous clear.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            perf_cnt  <= '0;
            stall_cnt <= 16'h0000;
        end else if (perf_clr) begin
            perf_cnt  <= '0;
            stall_cnt <= 16'h0000;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt[k] && perf_cnt[k] != 16'hFFFF) perf_cnt[k] <= perf_cnt[k] + 16'd1;
            end
            if (|req_vld && credit_cnt == 3'd0 && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_out_sched.sv
// tb_fpu_out_sched: directed scenarios with literal expectations, then a
// randomized run; every cycle the DUT outputs are compared against a
// behavioural model of the scheduler's rules.
module tb_fpu_out_sched;

    localparam int ID_W       = 10;
    localparam int CREDITS    = 2;
    localparam int STARVE_MAX = 7;

    localparam logic [9:0] ID_ADD  = 10'b101_10_00000;
    localparam logic [9:0] ID_MUL  = 10'b111_01_00101;
    localparam logic [9:0] ID_DIV  = 10'b011_11_01010;
    localparam logic [9:0] ID_DIV2 = 10'b000_00_11111;

    logic        rclk   = 1'b0;
    logic        arst_l = 1'b1;
    logic [2:0]  req_vld = 3'b000;
    logic [29:0] req_id  = '0;
    logic        cpx_credit_ret = 1'b0;
    logic [2:0]  dest_rdy;
    logic [7:0]  fp_cpx_req_cq;
    logic [1:0]  req_thread;
    logic [2:0]  credit_cnt;
    logic        credit_ovf;

    int checks = 0;
    int errors = 0;

    // model state
    int         mCredits;
    int         mPtr;
    int         mPrevWin;
    int         mStarve [3];
    bit         mOvf;
    logic [7:0] mCq;
    logic [1:0] mThr;
    logic [2:0] mDest;

    // random-phase requester state
    bit         pend [3];
    logic [9:0] pid  [3];

    fpu_out_sched #(
        .ID_W       (ID_W),
        .CREDITS    (CREDITS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .req_vld        (req_vld),
        .req_id         (req_id),
        .cpx_credit_ret (cpx_credit_ret),
        .dest_rdy       (dest_rdy),
        .fp_cpx_req_cq  (fp_cpx_req_cq),
        .req_thread     (req_thread),
        .credit_cnt     (credit_cnt),
        .credit_ovf     (credit_ovf)
    );

    always #5 rclk = ~rclk;

    function automatic void modelReset();
        mCredits = CREDITS;
        mPtr     = 0;
        mPrevWin = -1;
        for (int k = 0; k < 3; k++) mStarve[k] = 0;
        mOvf  = 1'b0;
        mCq   = 8'h00;
        mThr  = 2'b00;
        mDest = 3'b000;
    endfunction

    // One clock of the scheduler rules, using the inputs present at the edge.
    function automatic void modelStep();
        int win;
        logic [ID_W-1:0] wid;
        win = -1;
        if (mCredits > 0) begin
            for (int k = 0; k < 3; k++) begin
                if (win < 0 && req_vld[k] && mPrevWin != k && mStarve[k] >= STARVE_MAX) win = k;
            end
            for (int i = 0; i < 3; i++) begin
                int k = (mPtr + i) % 3;
                if (win < 0 && req_vld[k] && mPrevWin != k) win = k;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (!req_vld[k] || win == k)     mStarve[k] = 0;
            else if (mStarve[k] < STARVE_MAX) mStarve[k] = mStarve[k] + 1;
        end
        if (win >= 0 && !cpx_credit_ret) begin
            mCredits = mCredits - 1;
        end else if (win < 0 && cpx_credit_ret) begin
            if (mCredits == CREDITS) mOvf = 1'b1;
            else                     mCredits = mCredits + 1;
        end
        if (win >= 0) begin
            wid   = req_id[win*ID_W +: ID_W];
            mCq   = 8'h01 << wid[9:7];
            mThr  = wid[6:5];
            mDest = 3'b001 << win;
            mPtr  = (win + 1) % 3;
        end else begin
            mCq   = 8'h00;
            mDest = 3'b000;
        end
        mPrevWin = win;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("dest_rdy",      32'(dest_rdy),      32'(mDest));
        checkValue("fp_cpx_req_cq", 32'(fp_cpx_req_cq), 32'(mCq));
        checkValue("req_thread",    32'(req_thread),    32'(mThr));
        checkValue("credit_cnt",    32'(credit_cnt),    32'(mCredits));
        checkValue("credit_ovf",    32'(credit_ovf),    32'(mOvf));
    endtask

    task automatic applyStimulus(input logic [2:0] vld, input logic [9:0] idA,
                                 input logic [9:0] idM, input logic [9:0] idD, input logic ret);
        req_vld        = vld;
        req_id         = {idD, idM, idA};
        cpx_credit_ret = ret;
    endtask

    task automatic stepCycle();
        @(posedge rclk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_dest"},   32'(dest_rdy),      32'h0);
        checkValue({tag, "_cq"},     32'(fp_cpx_req_cq), 32'h0);
        checkValue({tag, "_thr"},    32'(req_thread),    32'h0);
        checkValue({tag, "_credit"}, 32'(credit_cnt),    32'(CREDITS));
        checkValue({tag, "_ovf"},    32'(credit_ovf),    32'h0);
    endtask

    initial begin
        modelReset();
        #1 arst_l = 1'b0;
        #11;
        checkResetValues("por");
        #1 arst_l = 1'b1;

        // three ready at once: add, then mul, then nothing left credit for div
        applyStimulus(3'b111, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("g1_dest", 32'(dest_rdy), 32'h1);
        checkValue("g1_cq",   32'(fp_cpx_req_cq), 32'h20);
        checkValue("g1_thr",  32'(req_thread), 32'h2);
        checkValue("g1_cred", 32'(credit_cnt), 32'h1);
        applyStimulus(3'b110, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("g2_dest", 32'(dest_rdy), 32'h2);
        checkValue("g2_cq",   32'(fp_cpx_req_cq), 32'h80);
        checkValue("g2_cred", 32'(credit_cnt), 32'h0);

        // asynchronous reset while mul holds the grant
        arst_l = 1'b0;
        #1;
        checkResetValues("midrst");
        modelReset();
        #1 arst_l = 1'b1;

        applyStimulus(3'b111, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("r1_dest", 32'(dest_rdy), 32'h1);
        checkValue("r1_cred", 32'(credit_cnt), 32'h1);
        applyStimulus(3'b110, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("r2_dest", 32'(dest_rdy), 32'h2);
        applyStimulus(3'b100, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("r3_dest", 32'(dest_rdy), 32'h0);
        checkValue("r3_cq",   32'(fp_cpx_req_cq), 32'h0);
        checkValue("r3_thr",  32'(req_thread), 32'h1);
        checkValue("r3_cred", 32'(credit_cnt), 32'h0);
        for (int i = 0; i < 3; i++) stepCycle();

        // credit return lets the waiting div through one cycle later
        applyStimulus(3'b100, ID_ADD, ID_MUL, ID_DIV, 1'b1); stepCycle();
        checkValue("ret_cred", 32'(credit_cnt), 32'h1);
        checkValue("ret_dest", 32'(dest_rdy), 32'h0);
        applyStimulus(3'b100, ID_ADD, ID_MUL, ID_DIV, 1'b0); stepCycle();
        checkValue("div_dest", 32'(dest_rdy), 32'h4);
        checkValue("div_cred", 32'(credit_cnt), 32'h0);
        checkValue("div_cq",   32'(fp_cpx_req_cq), 32'h08);

        // starved div beats add even though the rr pointer favours add
        applyStimulus(3'b100, ID_ADD, ID_MUL, ID_DIV2, 1'b0);
        for (int i = 0; i < 9; i++) stepCycle();
        applyStimulus(3'b100, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        checkValue("sv_cred", 32'(credit_cnt), 32'h1);
        applyStimulus(3'b111, ID_ADD, ID_MUL, ID_DIV2, 1'b0); stepCycle();
        checkValue("sv_dest", 32'(dest_rdy), 32'h4);
        checkValue("sv_cq",   32'(fp_cpx_req_cq), 32'h01);

        // grant and return together leave the count unchanged
        applyStimulus(3'b011, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        checkValue("gr0_cred", 32'(credit_cnt), 32'h1);
        applyStimulus(3'b011, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        checkValue("gr_dest", 32'(dest_rdy), 32'h1);
        checkValue("gr_cred", 32'(credit_cnt), 32'h1);
        applyStimulus(3'b010, ID_ADD, ID_MUL, ID_DIV2, 1'b0); stepCycle();
        checkValue("gm_dest", 32'(dest_rdy), 32'h2);
        checkValue("gm_cred", 32'(credit_cnt), 32'h0);

        // refill to full, then one return too many sets the sticky flag
        applyStimulus(3'b000, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        applyStimulus(3'b000, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        checkValue("full_cred", 32'(credit_cnt), 32'h2);
        checkValue("full_ovf",  32'(credit_ovf), 32'h0);
        applyStimulus(3'b000, ID_ADD, ID_MUL, ID_DIV2, 1'b1); stepCycle();
        checkValue("ovf_set",  32'(credit_ovf), 32'h1);
        checkValue("ovf_cred", 32'(credit_cnt), 32'h2);
        applyStimulus(3'b000, ID_ADD, ID_MUL, ID_DIV2, 1'b0); stepCycle();
        checkValue("ovf_hold", 32'(credit_ovf), 32'h1);

        // randomized traffic under the requester contract
        arst_l = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #1 arst_l = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1'b0;
            pid[k]  = 10'h000;
        end
        for (int c = 0; c < 3000; c++) begin
            logic ret;
            if (c == 1500) begin
                arst_l = 1'b0;
                #1;
                modelReset();
                checkOutput();
                #1 arst_l = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (mPrevWin == k) begin
                    pend[k] = ($urandom_range(0, 1) == 1);
                    pid[k]  = 10'($urandom);
                end else if (!pend[k]) begin
                    pend[k] = ($urandom_range(0, 2) == 0);
                    pid[k]  = 10'($urandom);
                end
            end
            ret = ((CREDITS - mCredits) > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 39) == 0);
            if ((c % 300) >= 250) ret = 1'b0;
            applyStimulus({pend[2], pend[1], pend[0]}, pid[0], pid[1], pid[2], ret);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
